// File: rtl/multi_pin_toggle_pkg.sv
// Shared definitions for the multi_pin_toggle block: per-channel mode
// encodings and the elaboration-time parameter range check.
package multi_pin_toggle_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_STRETCH = 2'b10,
    MODE_OFF     = 2'b11
  } pin_mode_e;

  function automatic bit params_ok(input int unsigned num_ch, sync_stages,
                                   deb_cycles, pulse_len);
    return (num_ch >= 1) && (num_ch <= 16) &&
           (sync_stages >= 2) && (sync_stages <= 4) &&
           (deb_cycles >= 1) && (deb_cycles <= 65535) &&
           (pulse_len >= 1) && (pulse_len <= 32'h00FF_FFFF);
  endfunction

endpackage

// File: rtl/multi_pin_toggle_pin_chan.sv
// One pin channel: synchroniser, debounce filter, rising-edge detect and
// mode-dependent registered pad drive (pass / toggle / stretch / off).
module pin_chan
  import multi_pin_toggle_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned PULSE_LEN   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin,
  input  logic [1:0] mode,
  output logic       drive,
  output logic       filt
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned STR_W = $clog2(PULSE_LEN + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(PULSE_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DEB_W-1:0]       deb_cnt;
  logic                   filt_d;
  logic [1:0]             mode_q;
  logic                   tog_q;
  logic [STR_W-1:0]       str_cnt;

  logic                   sync;
  logic                   rise;
  logic                   mode_chg;
  logic                   tog_cur, tog_nxt;
  logic [STR_W-1:0]       str_cur, str_nxt;
  logic                   drive_nxt;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign rise     = filt & ~filt_d;
  assign mode_chg = (mode != mode_q);

  // A mode change zeroes the per-mode state first, then the new mode's
  // rule is applied in the same cycle.
  always_comb begin
    tog_cur   = mode_chg ? 1'b0 : tog_q;
    str_cur   = mode_chg ? '0 : str_cnt;
    tog_nxt   = tog_cur;
    str_nxt   = str_cur;
    drive_nxt = 1'b0;
    case (pin_mode_e'(mode))
      MODE_PASS:    drive_nxt = filt;
      MODE_TOGGLE: begin
        tog_nxt   = tog_cur ^ rise;
        drive_nxt = tog_nxt;
      end
      MODE_STRETCH: begin
        if (rise)
          str_nxt = STR_LOAD;
        else if (str_cur != '0)
          str_nxt = str_cur - STR_W'(1);
        drive_nxt = (str_nxt != '0);
      end
      MODE_OFF:     drive_nxt = 1'b0;
      default:      drive_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      deb_cnt <= '0;
      filt    <= 1'b0;
      filt_d  <= 1'b0;
      mode_q  <= '0;
      tog_q   <= 1'b0;
      str_cnt <= '0;
      drive   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      if (sync == filt) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        filt    <= sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
      filt_d  <= filt;
      mode_q  <= mode;
      tog_q   <= tog_nxt;
      str_cnt <= str_nxt;
      drive   <= drive_nxt;
    end
  end

endmodule

// File: rtl/multi_pin_toggle.sv
// Top level: NUM_CH independent pin channels with per-channel mode select
// and debounced level readback.
module multi_pin_toggle
  import multi_pin_toggle_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned PULSE_LEN   = 1000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [NUM_CH-1:0]     i_Pin,
  input  logic [2*NUM_CH-1:0]   i_Mode,
  output logic [NUM_CH-1:0]     o_Pin,
  output logic [NUM_CH-1:0]     o_Filt
);

  if (!params_ok(NUM_CH, SYNC_STAGES, DEB_CYCLES, PULSE_LEN)) begin : g_bad_params
    $error("multi_pin_toggle: parameter out of range");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    pin_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES),
      .PULSE_LEN  (PULSE_LEN)
    ) u_chan (
      .clk  (i_Clk),
      .rst  (i_Rst),
      .pin  (i_Pin[g]),
      .mode (i_Mode[2*g+1 -: 2]),
      .drive(o_Pin[g]),
      .filt (o_Filt[g])
    );
  end

endmodule

// File: tb/tb_multi_pin_toggle.sv
// Directed self-checking bench for multi_pin_toggle with NUM_CH=2,
// SYNC_STAGES=2, DEB_CYCLES=4, PULSE_LEN=8.
module tb_multi_pin_toggle;
  import multi_pin_toggle_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] pin;
  logic [3:0] mode;
  logic [1:0] o_pin;
  logic [1:0] o_filt;

  int n_checks = 0;
  int n_errors = 0;

  multi_pin_toggle #(
    .NUM_CH     (2),
    .SYNC_STAGES(2),
    .DEB_CYCLES (4),
    .PULSE_LEN  (8)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .i_Pin (pin),
    .i_Mode(mode),
    .o_Pin (o_pin),
    .o_Filt(o_filt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clean pulse on ch0: high for 10 cycles, low for 10 cycles.
  task automatic pulse0();
    pin[0] = 1'b1;
    repeat (10) tick();
    pin[0] = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    rst  = 1'b1;
    pin  = '0;
    mode = '0;
    #2;
    chk("rst_opin", int'(o_pin), 0);
    chk("rst_ofilt", int'(o_filt), 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // PASS latency: o_Filt at 6 cycles, o_Pin at 7.
    pin[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("pass_filt_k%0d", k), int'(o_filt[0]), (k >= 6) ? 1 : 0);
      chk($sformatf("pass_pin_k%0d", k), int'(o_pin[0]), (k >= 7) ? 1 : 0);
    end

    // Three-cycle glitch on ch1 must be swallowed.
    pin[1] = 1'b1;
    repeat (3) tick();
    pin[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("glitch_filt_k%0d", k), int'(o_filt[1]), 0);
      chk($sformatf("glitch_pin_k%0d", k), int'(o_pin[1]), 0);
    end

    pin[0] = 1'b0;
    repeat (10) tick();
    chk("pass_fall", int'(o_pin[0]), 0);

    // TOGGLE: three pulses give 1, 0, 1 with first-edge timing checked.
    mode[1:0] = MODE_TOGGLE;
    repeat (2) tick();
    chk("tog_start", int'(o_pin[0]), 0);
    for (int p = 0; p < 3; p++) begin
      int prev_v;
      prev_v = p % 2;
      pin[0] = 1'b1;
      repeat (6) tick();
      chk($sformatf("tog%0d_before", p), int'(o_pin[0]), prev_v);
      tick();
      chk($sformatf("tog%0d_after", p), int'(o_pin[0]), 1 - prev_v);
      repeat (3) tick();
      pin[0] = 1'b0;
      repeat (10) tick();
      chk($sformatf("tog%0d_hold", p), int'(o_pin[0]), 1 - prev_v);
      chk($sformatf("tog%0d_ch1", p), int'(o_pin[1]), 0);
    end

    // STRETCH with retrigger: strobes load at cycles 7 and 15, so high 7..22.
    mode[1:0] = MODE_STRETCH;
    tick();
    chk("str_modechg", int'(o_pin[0]), 0);
    repeat (3) tick();
    pin[0] = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      tick();
      chk($sformatf("str_k%0d", k), int'(o_pin[0]), (k >= 7 && k <= 22) ? 1 : 0);
      if (k == 4) pin[0] = 1'b0;
      if (k == 8) pin[0] = 1'b1;
    end
    pin[0] = 1'b0;
    repeat (12) tick();
    chk("str_idle", int'(o_pin[0]), 0);

    // Reset mid-pulse at counter value 3 (12 cycles after pin rise).
    pin[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) pin[0] = 1'b0;
    end
    chk("strrst_pre", int'(o_pin[0]), 1);
    rst = 1'b1;
    #1;
    chk("strrst_async_pin", int'(o_pin[0]), 0);
    chk("strrst_async_filt", int'(o_filt), 0);
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("strrst_after_k%0d", k), int'(o_pin[0]), 0);
    end

    // TOGGLE(1) -> OFF -> TOGGLE clears toggle state until the next edge.
    mode[1:0] = MODE_TOGGLE;
    tick();
    pulse0();
    chk("msw_tog1", int'(o_pin[0]), 1);
    mode[1:0] = MODE_OFF;
    tick();
    chk("msw_off", int'(o_pin[0]), 0);
    mode[1:0] = MODE_TOGGLE;
    tick();
    chk("msw_back", int'(o_pin[0]), 0);
    repeat (10) tick();
    chk("msw_hold", int'(o_pin[0]), 0);
    pulse0();
    chk("msw_edge", int'(o_pin[0]), 1);

    // Pins held high through reset: both channels rise together afterwards.
    mode = '0;
    pin  = 2'b11;
    rst  = 1'b1;
    #1;
    chk("hold_rst_opin", int'(o_pin), 0);
    chk("hold_rst_ofilt", int'(o_filt), 0);
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("both_filt_k%0d", k), int'(o_filt), (k >= 6) ? 3 : 0);
      chk($sformatf("both_pin_k%0d", k), int'(o_pin), (k >= 7) ? 3 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
